// File: rtl/product_reg.sv
// product_reg
//   64-bit Product register of a sequential shift-add multiplier. The low
//   half is loaded with the multiplier and the high half accumulates the
//   partial product, which is written from the adder and shifted right one bit
//   per step under controller direction.
//
// Ports
//   clk            system clock, rising-edge active
//   Reset          asynchronous active-low reset (clears P, arms the load)
//   SRL_ctrl       shift-right-logical enable
//   W_ctrl         write enable for the high half from the adder
//   Ready          multiply complete; freezes all state
//   ALU_carry      adder carry-out, enters bit 2*WIDTH-1 on write+shift
//   ALU_result     adder sum (partial-product high half + multiplicand)
//   Multiplier_in  multiplier operand, loaded into the low half
//   Product_out    register contents, straight from the flops
module product_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               SRL_ctrl,
  input  logic               W_ctrl,
  input  logic               Ready,
  input  logic               ALU_carry,
  input  logic [WIDTH-1:0]   ALU_result,
  input  logic [WIDTH-1:0]   Multiplier_in,
  output logic [2*WIDTH-1:0] Product_out
);

  logic [2*WIDTH-1:0] r_p;
  logic               r_load_pending;
  logic [2*WIDTH-1:0] w_p_next;
  logic               w_load_pending_next;

  // Strict priority: Ready freeze, pending load, write+shift, write, shift.
  // ALU inputs are only consulted in the branches where W_ctrl is set.
  always_comb begin
    w_p_next            = r_p;
    w_load_pending_next = r_load_pending;
    if (Ready) begin
      w_p_next            = r_p;
      w_load_pending_next = r_load_pending;
    end else if (r_load_pending) begin
      w_p_next            = {{WIDTH{1'b0}}, Multiplier_in};
      w_load_pending_next = 1'b0;
    end else if (W_ctrl && SRL_ctrl) begin
      w_p_next = {ALU_carry, ALU_result, r_p[WIDTH-1:1]};
    end else if (W_ctrl) begin
      w_p_next = {ALU_result, r_p[WIDTH-1:0]};
    end else if (SRL_ctrl) begin
      w_p_next = {1'b0, r_p[2*WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_p            <= '0;
      r_load_pending <= 1'b1;
    end else begin
      r_p            <= w_p_next;
      r_load_pending <= w_load_pending_next;
    end
  end

  assign Product_out = r_p;

endmodule

// File: tb/tb_product_reg.sv
module tb_product_reg;

  localparam int unsigned W = 32;

  logic            clk = 1'b0;
  logic            Reset;
  logic            SRL_ctrl;
  logic            W_ctrl;
  logic            Ready;
  logic            ALU_carry;
  logic [W-1:0]    ALU_result;
  logic [W-1:0]    Multiplier_in;
  logic [2*W-1:0]  Product_out;

  logic [2*W-1:0]  sb[$];
  logic [2*W-1:0]  exp;
  int unsigned     n_cmp = 0;
  int unsigned     n_err = 0;

  product_reg #(.WIDTH(W)) dut (
    .clk           (clk),
    .Reset         (Reset),
    .SRL_ctrl      (SRL_ctrl),
    .W_ctrl        (W_ctrl),
    .Ready         (Ready),
    .ALU_carry     (ALU_carry),
    .ALU_result    (ALU_result),
    .Multiplier_in (Multiplier_in),
    .Product_out   (Product_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // Advance one rising edge and land 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse Reset between edges and let the next edge perform the load.
  task automatic reload(input logic [W-1:0] mult);
    Ready         = 1'b0;
    Multiplier_in = mult;
    Reset         = 1'b0;
    #2;
    Reset         = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    Reset         = 1'b0;
    Ready         = 1'b0;
    W_ctrl        = 1'b1;
    SRL_ctrl      = 1'b1;
    ALU_carry     = 1'b1;
    ALU_result    = 32'hDEAD_BEEF;
    Multiplier_in = 32'hFFFF_FFFF;
    #2;
    n_cmp++;
    if (Product_out !== 64'd0) begin
      n_err++;
      $display("FAIL reset_immediate: got %h expected %h", Product_out, 64'd0);
    end
    tick();
    n_cmp++;
    if (Product_out !== 64'd0) begin
      n_err++;
      $display("FAIL reset_held: got %h expected %h", Product_out, 64'd0);
    end
    #2;
    Reset = 1'b1;
    sb.push_back(64'h0000_0000_FFFF_FFFF);
    tick();
    exp = sb.pop_front();
    n_cmp++;
    if (Product_out !== exp) begin
      n_err++;
      $display("FAIL load_wins: got %h expected %h", Product_out, exp);
    end
  endtask

  task automatic test_write_shift();
    reload(32'hFFFF_FFFF);
    W_ctrl = 1'b1; SRL_ctrl = 1'b1;
    ALU_result = 32'h0000_000A; ALU_carry = 1'b1;
    sb.push_back(64'h8000_0005_7FFF_FFFF);
    tick();
    exp = sb.pop_front();
    n_cmp++;
    if (Product_out !== exp) begin
      n_err++;
      $display("FAIL write_shift: got %h expected %h", Product_out, exp);
    end
  endtask

  task automatic test_shift();
    reload(32'hFFFF_FFFF);
    W_ctrl = 1'b0; SRL_ctrl = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      ALU_result = $urandom;
      ALU_carry  = 1'($urandom_range(0, 1));
      sb.push_back(64'h0000_0000_FFFF_FFFF >> k);
      tick();
      exp = sb.pop_front();
      n_cmp++;
      if (Product_out !== exp) begin
        n_err++;
        $display("FAIL shift[%0d]: got %h expected %h", k, Product_out, exp);
      end
    end
  endtask

  task automatic test_write_only();
    reload(32'hFFFF_FFFF);
    W_ctrl = 1'b1; SRL_ctrl = 1'b0;
    ALU_result = 32'h1234_5678; ALU_carry = 1'b1;
    sb.push_back(64'h1234_5678_FFFF_FFFF);
    tick();
    exp = sb.pop_front();
    n_cmp++;
    if (Product_out !== exp) begin
      n_err++;
      $display("FAIL write_only: got %h expected %h", Product_out, exp);
    end
    // No enables: hold, whatever the adder presents.
    W_ctrl = 1'b0; SRL_ctrl = 1'b0;
    ALU_result = 32'hA5A5_5A5A; ALU_carry = 1'b1;
    sb.push_back(64'h1234_5678_FFFF_FFFF);
    tick();
    exp = sb.pop_front();
    n_cmp++;
    if (Product_out !== exp) begin
      n_err++;
      $display("FAIL hold_idle: got %h expected %h", Product_out, exp);
    end
    // Shift only: ALU inputs ignored, zero enters the top.
    SRL_ctrl = 1'b1;
    sb.push_back(64'h091A_2B3C_7FFF_FFFF);
    tick();
    exp = sb.pop_front();
    n_cmp++;
    if (Product_out !== exp) begin
      n_err++;
      $display("FAIL shift_ignores_alu: got %h expected %h", Product_out, exp);
    end
  endtask

  task automatic test_ready();
    reload(32'hFFFF_FFFF);
    Ready = 1'b1; W_ctrl = 1'b1; SRL_ctrl = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ALU_result = $urandom;
      ALU_carry  = 1'(i & 1);
      sb.push_back(64'h0000_0000_FFFF_FFFF);
      tick();
      exp = sb.pop_front();
      n_cmp++;
      if (Product_out !== exp) begin
        n_err++;
        $display("FAIL ready_freeze[%0d]: got %h expected %h", i, Product_out, exp);
      end
    end
    Ready = 1'b0;
    ALU_result = 32'h0000_000A; ALU_carry = 1'b1;
    sb.push_back(64'h8000_0005_7FFF_FFFF);
    tick();
    exp = sb.pop_front();
    n_cmp++;
    if (Product_out !== exp) begin
      n_err++;
      $display("FAIL ready_resume: got %h expected %h", Product_out, exp);
    end
    // Ready also outranks a pending load.
    Multiplier_in = 32'h0000_0042;
    Reset = 1'b0;
    #2;
    Reset = 1'b1;
    Ready = 1'b1;
    sb.push_back(64'd0);
    tick();
    exp = sb.pop_front();
    n_cmp++;
    if (Product_out !== exp) begin
      n_err++;
      $display("FAIL ready_blocks_load: got %h expected %h", Product_out, exp);
    end
    Ready = 1'b0;
    sb.push_back(64'h0000_0000_0000_0042);
    tick();
    exp = sb.pop_front();
    n_cmp++;
    if (Product_out !== exp) begin
      n_err++;
      $display("FAIL load_after_ready: got %h expected %h", Product_out, exp);
    end
  endtask

  // Controller + adder behaviour for one shift-add step.
  task automatic mul_step(input logic [W-1:0] mcand);
    logic [W:0] sum;
    sum = {1'b0, Product_out[2*W-1:W]} + {1'b0, mcand};
    if (Product_out[0]) begin
      W_ctrl = 1'b1; ALU_result = sum[W-1:0]; ALU_carry = sum[W];
    end else begin
      W_ctrl = 1'b0; ALU_result = $urandom; ALU_carry = 1'b1;
    end
    SRL_ctrl = 1'b1;
    tick();
  endtask

  // After k steps: (mcand * low k bits of mult) << (W-k), plus mult >> k.
  function automatic logic [2*W-1:0] mul_model(input logic [W-1:0] mcand,
                                               input logic [W-1:0] mult,
                                               input int unsigned k);
    logic [2*W-1:0] mask;
    logic [2*W-1:0] partial;
    mask    = (64'd1 << k) - 64'd1;
    partial = 64'(mcand) * (64'(mult) & mask);
    return (partial << (W - k)) + (64'(mult) >> k);
  endfunction

  task automatic test_multiply();
    reload(32'd5);
    for (int unsigned k = 1; k <= 32; k++) begin
      sb.push_back(mul_model(32'd7, 32'd5, k));
      mul_step(32'd7);
      exp = sb.pop_front();
      n_cmp++;
      if (Product_out !== exp) begin
        n_err++;
        $display("FAIL mul_step[%0d]: got %h expected %h", k, Product_out, exp);
      end
    end
    Ready = 1'b1; W_ctrl = 1'b1; SRL_ctrl = 1'b1;
    ALU_result = 32'hFFFF_FFFF; ALU_carry = 1'b1;
    sb.push_back(64'h0000_0000_0000_0023);
    tick();
    tick();
    exp = sb.pop_front();
    n_cmp++;
    if (Product_out !== exp) begin
      n_err++;
      $display("FAIL mul_result: got %h expected %h", Product_out, exp);
    end
  endtask

  task automatic test_reset_midrun();
    reload(32'd5);
    for (int unsigned k = 0; k < 3; k++) mul_step(32'd7);
    W_ctrl = 1'b1; SRL_ctrl = 1'b1; ALU_result = 32'h1111_1111; ALU_carry = 1'b1;
    Multiplier_in = 32'd9;
    Reset = 1'b0;
    #1;
    n_cmp++;
    if (Product_out !== 64'd0) begin
      n_err++;
      $display("FAIL midrun_abort: got %h expected %h", Product_out, 64'd0);
    end
    tick();
    n_cmp++;
    if (Product_out !== 64'd0) begin
      n_err++;
      $display("FAIL midrun_held: got %h expected %h", Product_out, 64'd0);
    end
    #2;
    Reset = 1'b1;
    sb.push_back(64'h0000_0000_0000_0009);
    tick();
    exp = sb.pop_front();
    n_cmp++;
    if (Product_out !== exp) begin
      n_err++;
      $display("FAIL midrun_reload: got %h expected %h", Product_out, exp);
    end
    W_ctrl = 1'b0; SRL_ctrl = 1'b1;
    sb.push_back(64'h0000_0000_0000_0004);
    tick();
    exp = sb.pop_front();
    n_cmp++;
    if (Product_out !== exp) begin
      n_err++;
      $display("FAIL midrun_resume: got %h expected %h", Product_out, exp);
    end
  endtask

  initial begin
    test_reset();
    test_write_shift();
    test_shift();
    test_write_only();
    test_ready();
    test_multiply();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
